// File: rtl/spi_dac_scheduler.sv
// Shares one 4-channel SPI DAC between four sample streams: latest-sample holding
// registers, round-robin arbitration and a clk/2 serializer for 24-bit frames.
module spi_dac_scheduler #(
    parameter logic [3:0] CMD       = 4'b0011,
    parameter int         MIN_GAP   = 2,
    parameter bit         OVERWRITE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_chan,
    input  logic [11:0] wr_data,
    output logic        spi_sck,
    output logic        spi_sdo,
    output logic        spi_dac_cs,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  done_chan
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam int         GW      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic [1:0]    state;
    logic [11:0]   hold [4];
    logic [3:0]    pending;
    logic [1:0]    last_chan;
    logic [1:0]    cur_chan;
    logic [23:0]   shreg;
    logic [5:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;

    logic          wr_fire;
    logic          grant_any;
    logic [1:0]    grant_chan;
    logic          do_grant;
    logic [3:0]    grant_mask;
    logic [3:0]    write_mask;

    assign wr_ready   = OVERWRITE ? 1'b1 : ~pending[wr_chan];
    assign wr_fire    = wr_valid & wr_ready;
    assign do_grant   = (state == S_IDLE) && grant_any;
    assign grant_mask = do_grant ? (4'b0001 << grant_chan) : 4'b0000;
    assign write_mask = wr_fire ? (4'b0001 << wr_chan) : 4'b0000;
    assign spi_sdo    = shreg[23];

    // Scan from the channel after the last served one; the lowest offset wins.
    always_comb begin
        grant_any  = 1'b0;
        grant_chan = last_chan;
        for (int k = 4; k >= 1; k--) begin
            if (pending[last_chan + 2'(k)]) begin
                grant_any  = 1'b1;
                grant_chan = last_chan + 2'(k);
            end
        end
    end

    // A write in the grant cycle re-sets the bit the grant clears, so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 4'b0000;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | write_mask;
            if (wr_fire) hold[wr_chan] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_chan  <= 2'd3;
            cur_chan   <= 2'd0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            spi_sck    <= 1'b0;
            spi_dac_cs <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done_chan  <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (do_grant) begin
                        shreg      <= {CMD, 2'b00, grant_chan, hold[grant_chan], 4'h0};
                        cur_chan   <= grant_chan;
                        last_chan  <= grant_chan;
                        bit_cnt    <= '0;
                        spi_sck    <= 1'b0;
                        spi_dac_cs <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == 6'd47) begin
                        shreg      <= '0;
                        spi_sck    <= 1'b0;
                        spi_dac_cs <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        done_chan  <= cur_chan;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        spi_sck <= ~spi_sck;
                        if (spi_sck) shreg <= {shreg[22:0], 1'b0};
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(MIN_GAP - 1)) state <= S_IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// Randomized and directed bench for spi_dac_scheduler; outputs are predicted from
// grant times and frame words by an edge-indexed reference model.
module tb_spi_dac_scheduler;

    localparam int MIN_GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, wr_ready;
    logic [1:0]  wr_chan;
    logic [11:0] wr_data;
    logic        spi_sck, spi_sdo, spi_dac_cs, busy, frame_done;
    logic [1:0]  done_chan;

    logic        wr_valid2, wr_ready2;
    logic [1:0]  wr_chan2;
    logic [11:0] wr_data2;
    logic        sck2, sdo2, cs2, busy2, fd2;
    logic [1:0]  dc2;

    always #5 clk = ~clk;

    spi_dac_scheduler #(.CMD(4'b0011), .MIN_GAP(MIN_GAP), .OVERWRITE(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_data(wr_data), .spi_sck(spi_sck), .spi_sdo(spi_sdo),
        .spi_dac_cs(spi_dac_cs), .busy(busy), .frame_done(frame_done), .done_chan(done_chan)
    );

    spi_dac_scheduler #(.CMD(4'b0011), .MIN_GAP(MIN_GAP), .OVERWRITE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_chan(wr_chan2), .wr_data(wr_data2), .spi_sck(sck2), .spi_sdo(sdo2),
        .spi_dac_cs(cs2), .busy(busy2), .frame_done(fd2), .done_chan(dc2)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [1:0] c, input logic [11:0] d);
        @(negedge clk);
        #1;
        wr_valid = v;
        wr_chan  = c;
        wr_data  = d;
    endtask

    // Reference model: a frame granted at edge g drives CS low for edges g..g+47,
    // bit j/2 of the frame word after edge g+j, done pulse after g+48, next grant at g+49+MIN_GAP.
    int          edge_n = 0;
    bit          m_valid = 0;
    logic [11:0] m_hold [4];
    bit   [3:0]  m_pend;
    int          m_last, m_g, m_next_ok, m_chan, pick;
    bit          m_active;
    logic [23:0] m_word;
    logic        e_cs, e_sck, e_sdo, e_busy, e_fd;
    logic [1:0]  e_dc;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_hold[i] = '0;
            m_pend = '0; m_last = 3; m_active = 0; m_next_ok = edge_n + 1;
            m_valid = 1;
            e_cs = 1; e_sck = 0; e_sdo = 0; e_busy = 0; e_fd = 0; e_dc = 0;
        end else if (m_valid) begin
            if (!m_active && edge_n >= m_next_ok && m_pend != 0) begin
                pick = -1;
                for (int k = 4; k >= 1; k--) if (m_pend[(m_last + k) % 4]) pick = (m_last + k) % 4;
                m_word    = {4'h3, 2'b00, 2'(pick), m_hold[pick], 4'h0};
                m_chan    = pick;
                m_last    = pick;
                m_pend[pick] = 1'b0;
                m_g       = edge_n;
                m_active  = 1;
                m_next_ok = edge_n + 49 + MIN_GAP;
            end
            if (wr_valid) begin
                m_hold[wr_chan] = wr_data;
                m_pend[wr_chan] = 1'b1;
            end
            e_fd = 0;
            if (m_active && (edge_n - m_g) < 48) begin
                e_cs = 0; e_busy = 1;
                e_sck = 1'((edge_n - m_g) % 2);
                e_sdo = m_word[23 - (edge_n - m_g) / 2];
            end else if (m_active) begin
                e_cs = 1; e_sck = 0; e_busy = 0; e_fd = 1; e_dc = 2'(m_chan);
                m_active = 0;
            end else begin
                e_cs = 1; e_sck = 0; e_busy = 0;
            end
        end
    end

    // Captured frames (sampled on sck rising) from the main DUT.
    logic [23:0] cap_q [$];
    int          bits_q [$];
    int          chan_q [$];
    int          start_q [$];
    logic [23:0] cap;
    int          nbits = 0;
    int          cyc = 0;
    logic        prev_sck = 0, prev_cs = 1;

    logic [23:0] cap2;
    int          nbits2 = 0, frames2 = 0;
    logic [23:0] last2;
    logic [1:0]  lastdc2;
    logic        prev_sck2 = 0;

    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            checkOutput("cs_sck_busy_fd", {28'd0, spi_dac_cs, spi_sck, busy, frame_done},
                        {28'd0, e_cs, e_sck, e_busy, e_fd});
            if (!e_cs) checkOutput("sdo", {31'd0, spi_sdo}, {31'd0, e_sdo});
            if (e_fd) checkOutput("done_chan", {30'd0, done_chan}, {30'd0, e_dc});
            checkOutput("wr_ready_ovr1", {31'd0, wr_ready}, 32'd1);
        end
        if (prev_cs && !spi_dac_cs) begin nbits = 0; start_q.push_back(cyc); end
        if (!spi_dac_cs && spi_sck && !prev_sck) begin cap = {cap[22:0], spi_sdo}; nbits++; end
        if (frame_done) begin cap_q.push_back(cap); bits_q.push_back(nbits); chan_q.push_back(int'(done_chan)); end
        prev_sck = spi_sck; prev_cs = spi_dac_cs;
        if (!cs2 && sck2 && !prev_sck2) begin cap2 = {cap2[22:0], sdo2}; nbits2++; end
        if (fd2) begin frames2++; last2 = cap2; lastdc2 = dc2; end
        prev_sck2 = sck2;
    end

    task automatic wait_frames(input int n, input int budget, input string name);
        int t = 0;
        while (cap_q.size() < n && t < budget) begin @(negedge clk); #1; t++; end
        if (cap_q.size() < n) begin
            checks++; errors++;
            $display("[TB] FAIL %s timeout frames=%0d wanted=%0d", name, cap_q.size(), n);
        end
    endtask

    task automatic idle_cycles(input int n);
        applyStimulus(0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    int base, t, cnt [4], low_cnt;

    initial begin
        reset = 1; wr_valid = 0; wr_chan = 0; wr_data = 0;
        wr_valid2 = 0; wr_chan2 = 0; wr_data2 = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pins", {27'd0, spi_dac_cs, spi_sck, spi_sdo, busy, frame_done},
                    {27'd0, 5'b10000});
        checkOutput("reset_done_chan", {30'd0, done_chan}, 32'd0);
        checkOutput("reset_pins2", {28'd0, cs2, sck2, busy2, fd2}, {28'd0, 4'b1000});
        #1 reset = 0;
        idle_cycles(3);

        $display("[TB] single write ch1");
        base = cap_q.size();
        applyStimulus(1, 1, 12'hABC);
        idle_cycles(1);
        wait_frames(base + 1, 200, "single_frame");
        if (cap_q.size() > base) begin
            checkOutput("single_word", cap_q[base], 32'h31ABC0);
            checkOutput("single_bits", bits_q[base], 32'd24);
            checkOutput("single_chan", chan_q[base], 32'd1);
        end
        idle_cycles(10);

        $display("[TB] three writes in one idle window");
        base = cap_q.size();
        applyStimulus(1, 0, 12'h100);
        applyStimulus(1, 2, 12'h222);
        applyStimulus(1, 3, 12'h333);
        idle_cycles(1);
        wait_frames(base + 3, 400, "three_frames");
        if (cap_q.size() >= base + 3) begin
            checkOutput("order0", chan_q[base], 32'd0);
            checkOutput("order1", chan_q[base + 1], 32'd2);
            checkOutput("order2", chan_q[base + 2], 32'd3);
            checkOutput("word0", cap_q[base], 32'h301000);
            checkOutput("word2", cap_q[base + 2], 32'h333330);
            checkOutput("period01", start_q[base + 1] - start_q[base], 32'(49 + MIN_GAP));
            checkOutput("period12", start_q[base + 2] - start_q[base + 1], 32'(49 + MIN_GAP));
        end
        idle_cycles(10);

        $display("[TB] write in grant cycle");
        base = cap_q.size();
        applyStimulus(1, 0, 12'h456);
        applyStimulus(1, 0, 12'h123);
        idle_cycles(1);
        wait_frames(base + 2, 400, "grant_cycle_frames");
        if (cap_q.size() >= base + 2) begin
            checkOutput("grant_old_word", cap_q[base], 32'h304560);
            checkOutput("grant_new_word", cap_q[base + 1], 32'h301230);
        end
        idle_cycles(10);

        $display("[TB] continuous writes, round robin");
        base = cap_q.size();
        for (int i = 0; i < 400; i++) applyStimulus(1, 2'(i % 4), 12'($urandom));
        idle_cycles(1);
        for (int i = base + 1; i < cap_q.size(); i++)
            checkOutput("rr_next", chan_q[i], (chan_q[i - 1] + 1) % 4);
        t = 0;
        while ((m_pend != 0 || m_active) && t < 2000) begin @(negedge clk); t++; end
        checkOutput("drain_rr", {31'd0, (m_pend != 0 || m_active)}, 32'd0);
        idle_cycles(5);

        $display("[TB] random traffic");
        base = cap_q.size();
        for (int i = 0; i < 2500; i++)
            applyStimulus($urandom_range(0, 99) < 35, 2'($urandom), 12'($urandom));
        idle_cycles(1);
        t = 0;
        while ((m_pend != 0 || m_active) && t < 2000) begin @(negedge clk); t++; end
        checkOutput("drain_random", {31'd0, (m_pend != 0 || m_active)}, 32'd0);
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int i = base; i < cap_q.size(); i++) cnt[chan_q[i]]++;
        for (int c = 0; c < 4; c++) checkOutput("served_each_chan", {31'd0, cnt[c] > 0}, 32'd1);
        idle_cycles(5);

        $display("[TB] OVERWRITE=0 instance");
        @(negedge clk); #1;
        wr_valid2 = 1; wr_chan2 = 2; wr_data2 = 12'h111;
        #1 checkOutput("ovr0_ready_free", {31'd0, wr_ready2}, 32'd1);
        @(negedge clk); #1;
        wr_data2 = 12'h999;
        #1 checkOutput("ovr0_ready_pending", {31'd0, wr_ready2}, 32'd0);
        @(negedge clk); #1;
        wr_valid2 = 0;
        t = 0;
        while (frames2 < 1 && t < 200) begin @(negedge clk); #1; t++; end
        checkOutput("ovr0_frames", frames2, 32'd1);
        checkOutput("ovr0_word", {8'd0, last2}, 32'h321110);
        checkOutput("ovr0_chan", {30'd0, lastdc2}, 32'd2);
        repeat (150) @(negedge clk);
        checkOutput("ovr0_no_second", frames2, 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 2, 12'h5A5);
        applyStimulus(1, 3, 12'h777);
        applyStimulus(0, 0, 0);
        t = 0;
        while (!(nbits >= 10 && !spi_dac_cs) && t < 200) begin @(negedge clk); #1; t++; end
        checkOutput("reached_bit10", {31'd0, nbits >= 10}, 32'd1);
        base = cap_q.size();
        reset = 1;
        @(negedge clk);
        checkOutput("abort_pins", {28'd0, spi_dac_cs, spi_sck, busy, frame_done}, {28'd0, 4'b1000});
        #1 reset = 0;
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (!spi_dac_cs) low_cnt++; end
        checkOutput("abort_no_frame", cap_q.size(), base);
        checkOutput("abort_cs_idle", low_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
